// File: rtl/aes_key_schedule_seq_if.sv
// Handshake and data bundle between the AES round-key generator and its
// neighbours: key load request on one side, round-key stream on the other.
interface aes_key_schedule_seq_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         done;

    // master: the controller that loads keys and consumes round keys
    modport master (
        output start, key_in, rk_ready,
        input  busy, rk_valid, rk_data, rk_round, done
    );

    // slave: the key schedule itself
    modport slave (
        input  start, key_in, rk_ready,
        output busy, rk_valid, rk_data, rk_round, done
    );
endinterface

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128 round-key generator: one expansion stage plus a key
// register, stepped once per accepted round key.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; key_in sampled on the accepting edge
// EMIT   | rk_data/rk_round hold a round key, advance on handshake
// FINISH | done pulse after the last key was accepted; start ignored
module aes_key_schedule_seq #(
    parameter int NUM_ROUNDS = 10
) (
    input logic                  clk,
    input logic                  rst,
    aes_key_schedule_seq_if.slave ks
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t       state;
    logic [127:0] key_reg;
    logic [127:0] key_next;
    logic [3:0]   round_q;
    logic         valid_q;
    logic         busy_q;
    logic         done_q;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as SubBytes requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    // SubBytes S-box: inverse followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = sbox(w[8*i +: 8]);
        end
        return r;
    endfunction

    // Round constant for the step that produces round idx+1
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [31:0] rot_w;
    logic [31:0] sub_w;
    logic [31:0] t_w;
    logic [31:0] n0, n1, n2, n3;

    // Single key-expansion step applied to the current round key
    always_comb begin
        rot_w    = {key_reg[103:96], key_reg[127:104]};
        sub_w    = sub_word(rot_w);
        t_w      = {sub_w[31:8], sub_w[7:0] ^ rcon(round_q)};
        n0       = key_reg[31:0]   ^ t_w;
        n1       = key_reg[63:32]  ^ n0;
        n2       = key_reg[95:64]  ^ n1;
        n3       = key_reg[127:96] ^ n2;
        key_next = {n3, n2, n1, n0};
    end

    // Control FSM: load, step on each handshake, pulse done, return to idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            key_reg <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (ks.start) begin
                        key_reg <= ks.key_in;
                        round_q <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (valid_q && ks.rk_ready) begin
                        if (round_q < LAST_ROUND) begin
                            key_reg <= key_next;
                            round_q <= round_q + 4'd1;
                        end else begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign ks.rk_data  = key_reg;
    assign ks.rk_round = round_q;
    assign ks.rk_valid = valid_q;
    assign ks.busy     = busy_q;
    assign ks.done     = done_q;

endmodule
